cla_serial_arb32: RTL and testbench

Shared-adder scheduler that time-multiplexes one 4-bit carry-lookahead slice (`cla4`) between two requesters to perform WIDTH-bit additions nibble-serially. It arbitrates round-robin, captures the winner's operands, steps the slice LSB-first over WIDTH/4 cycles through a registered inter-slice carry, and returns sum, carry-out and requester ID with a one-cycle valid pulse. It sits between the `cla4` datapath and client logic that needs occasional wide adds without paying for a full-width CLA tree.

---
 rtl/cla_serial_arb32.sv | 152 +++++++++++++++
 tb/tb_cla_serial_arb32.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_arb32.sv
// Two-requester round-robin scheduler that time-shares one 4-bit CLA slice for WIDTH-bit adds.
// Grant to valid is WIDTH/4+1 cycles; requests are sampled only in IDLE, so a waiting requester simply holds.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end
endmodule

module cla_serial_arb32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             ci0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             ci1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             valid,
  output logic             id,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, id_r_q, id_r_d, last_q, last_d, co_q, co_d, id_q, id_d;
  logic             win1;
  logic [3:0]       slice_s;
  logic             slice_co;

  cla4 u_cla4 (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (c_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // On a tie the requester that was not served last wins.
  always_comb begin
    win1 = req1 & (~req0 | ~last_q);
    gnt0 = (state_q == IDLE) & req0 & ~win1;
    gnt1 = (state_q == IDLE) & win1;
    busy  = (state_q != IDLE);
    valid = (state_q == DONE);
    s  = s_q;
    co = co_q;
    id = id_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    id_r_d  = id_r_q;
    last_d  = last_q;
    s_d     = s_q;
    co_d    = co_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          a_d     = win1 ? a1 : a0;
          b_d     = win1 ? b1 : b0;
          c_d     = win1 ? ci1 : ci0;
          id_r_d  = win1;
          last_d  = win1;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Sum fills from the top so it is aligned after the final nibble.
        sum_d = {slice_s, sum_q[WIDTH-1:4]};
        c_d   = slice_co;
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          s_d     = sum_d;
          co_d    = slice_co;
          id_d    = id_r_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      id_r_q  <= 1'b0;
      last_q  <= 1'b1;
      s_q     <= '0;
      co_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      id_r_q  <= id_r_d;
      last_q  <= last_d;
      s_q     <= s_d;
      co_q    <= co_d;
      id_q    <= id_d;
    end
  end
endmodule

// File: tb/tb_cla_serial_arb32.sv
// Randomized and directed bench for cla_serial_arb32 against a cycle-level reference model.
module tb_cla_serial_arb32;
  localparam int W = 32;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, ci0, ci1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, valid, id, co;
  logic [W-1:0] s;

  cla_serial_arb32 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .ci0(ci0),
    .req1(req1), .a1(a1), .b1(b1), .ci1(ci1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .valid(valid),
    .id(id), .s(s), .co(co)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: remaining cycles of the current operation (0 = free),
  // last-served requester, pending result and the held output values.
  int           rem;
  bit           m_last;
  bit [W:0]     cur_res;
  bit           cur_id;
  bit [W-1:0]   held_s;
  bit           held_co, held_id;
  int           cyc = 0;
  int           last_valid_cyc = -1000;
  int           n_valid = 0;
  bit           g0_prev, g1_prev;

  task automatic model_reset();
    rem     = 0;
    m_last  = 1'b1;
    held_s  = '0;
    held_co = 1'b0;
    held_id = 1'b0;
  endtask

  task automatic step();
    bit e0, e1;
    @(negedge clk);
    cyc++;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset && rem == 0 && (req0 || req1)) begin
      if (req0 && req1) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = req0;
        e1 = req1;
      end
    end
    if (rem == 1) begin
      held_s  = cur_res[W-1:0];
      held_co = cur_res[W];
      held_id = cur_id;
      n_valid++;
    end
    check("gnt0", gnt0, e0);
    check("gnt1", gnt1, e1);
    check("busy", busy, rem > 0);
    check("valid", valid, rem == 1);
    check("s", s, held_s);
    check("co", co, held_co);
    check("id", id, held_id);
    if (valid) begin
      check("valid_spacing", (cyc - last_valid_cyc) >= N + 2, 1'b1);
      last_valid_cyc = cyc;
    end
    g0_prev = e0;
    g1_prev = e1;
    if (e0 || e1) begin
      cur_res = e1 ? ({1'b0, a1} + {1'b0, b1} + (W+1)'(ci1))
                   : ({1'b0, a0} + {1'b0, b0} + (W+1)'(ci0));
      cur_id  = e1;
      m_last  = e1;
      rem     = N + 1;
    end else if (rem > 0) begin
      rem--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    req0 = 0; req1 = 0; ci0 = 0; ci1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    reset = 1'b1;
    model_reset();
    #1;
    do_reset();

    // Full-width carry ripple from requester 0.
    req0 = 1; a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; ci0 = 0;
    step();
    req0 = 0;
    repeat (N + 1) step();
    check("t1_s", s, 32'h0000_0000);
    check("t1_co", co, 1'b1);
    check("t1_id", id, 1'b0);

    // Carry-in crossing the first nibble boundary, requester 1.
    req1 = 1; a1 = 32'h0000_000F; b1 = 32'h0000_0000; ci1 = 1;
    step();
    req1 = 0;
    repeat (N + 1) step();
    check("t2_s", s, 32'h0000_0010);
    check("t2_co", co, 1'b0);
    check("t2_id", id, 1'b1);

    // Both held from reset: grants alternate 0,1,0.
    do_reset();
    req0 = 1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; ci0 = 0;
    req1 = 1; a1 = 32'h8000_0000; b1 = 32'h8000_0000; ci1 = 1;
    step();
    check("t3_first_gnt0", g0_prev, 1'b1);
    repeat (N + 1) step();
    check("t3_r0_s", s, 32'h2345_6789);
    step();
    check("t3_second_gnt1", g1_prev, 1'b1);
    repeat (N + 1) step();
    check("t3_r1_s", s, 32'h0000_0001);
    check("t3_r1_co", co, 1'b1);
    step();
    check("t3_third_gnt0", g0_prev, 1'b1);
    req0 = 0; req1 = 0;
    repeat (N + 1) step();
    check("t3_r2_s", s, 32'h2345_6789);
    check("t3_r2_id", id, 1'b0);

    // Reset in the middle of an add discards it.
    req0 = 1; a0 = 32'hDEAD_BEEF; b0 = 32'h0101_0101; ci0 = 1;
    step();
    req0 = 0;
    repeat (3) step();
    do_reset();
    check("t4_s", s, 32'h0);
    check("t4_co", co, 1'b0);
    check("t4_busy", busy, 1'b0);
    repeat (N + 2) step();
    req0 = 1; req1 = 1; a0 = 32'h0000_0005; b0 = 32'h0000_0007; ci0 = 0;
    step();
    check("t4_tie_gnt0", g0_prev, 1'b1);
    req0 = 0;
    // Requester 1 toggles and requester 0 operands change while the add runs.
    for (int i = 0; i < N + 1; i++) begin
      req1 = 1'($urandom);
      b0   = $urandom;
      step();
    end
    check("t5_s", s, 32'h0000_000C);
    req1 = 1;
    step();
    check("t5_gnt1_idle", g1_prev, 1'b1);
    req1 = 0;
    repeat (N + 1) step();

    // Random traffic from both requesters.
    n_valid = 0;
    begin
      int limit;
      limit = cyc + 40000;
      while (n_valid < 1000 && cyc < limit) begin
        if (!req0 || g0_prev || rem > 0 || $urandom_range(0, 7) == 0) begin
          req0 = ($urandom_range(0, 2) != 0);
          a0 = $urandom; b0 = $urandom; ci0 = 1'($urandom);
        end
        if (!req1 || g1_prev || rem > 0 || $urandom_range(0, 7) == 0) begin
          req1 = ($urandom_range(0, 2) != 0);
          a1 = $urandom; b1 = $urandom; ci1 = 1'($urandom);
        end
        step();
      end
      check("random_adds_done", n_valid >= 1000, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
